// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and width helper for the arbitrating mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin / fixed-priority picker over a ptr-masked doubled request vector
module rr_pick
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    localparam int DW = 2 * NUM_IN;

    logic [DW-1:0]    dreq;
    logic [SEL_W-1:0] start;

    // Lower copy loses bits below start; the upper copy supplies the wrapped-around requests.
    always_comb begin
        start = (rr_mode == MODE_RR) ? ptr : '0;
        dreq  = {req, req} & ~((DW'(1) << start) - DW'(1));
        idx   = '0;
        for (int i = DW - 1; i >= 0; i--)
            if (dreq[i]) idx = SEL_W'((i >= NUM_IN) ? i - NUM_IN : i);
        any        = |req;
        grant      = '0;
        grant[idx] = any;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbitrating mux with valid/ready handshakes and one registered output stage
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rr_mode,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  idx;
    logic [NUM_IN-1:0] grant;
    logic              any;
    logic              take;

    rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .rr_mode (rr_mode),
        .grant   (grant),
        .idx     (idx),
        .any     (any)
    );

    // Loading is allowed when the register is empty or being drained this edge.
    always_comb begin
        take     = any && !reset && (!out_valid || out_ready);
        in_ready = take ? grant : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[idx*WIDTH +: WIDTH];
            out_sel   <= idx;
            ptr       <= (idx == SEL_W'(NUM_IN - 1)) ? '0 : idx + SEL_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
